// File: rtl/minion_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM read port among N_REQ pixel fetchers.
// Define MINION_ARB_LOCK_EN to enable burst locking through the lock inputs.
module minion_rom_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = 19,
   parameter int DATA_W  = 3,
   parameter int ROM_LAT = 0
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] addr,
   input  logic [N_REQ-1:0]        lock,
   output logic [N_REQ-1:0]        gnt,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [DATA_W-1:0]       rom_data,
   output logic [DATA_W-1:0]       rdata,
   output logic [N_REQ-1:0]        rvalid
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [IDX_W-1:0] ptr;
   logic [N_REQ-1:0] elig;
   logic             any_gnt;
   logic [IDX_W-1:0] gnt_idx;

`ifdef MINION_ARB_LOCK_EN
   logic             owner_vld;
   logic [IDX_W-1:0] owner_idx;

   // A live owner masks everyone else out, even while its own req is low.
   always_comb begin
      elig = req;
      if (owner_vld) elig = req & (N_REQ'(1) << owner_idx);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         owner_vld <= 1'b0;
         owner_idx <= '0;
      end else if (any_gnt) begin
         owner_vld <= lock[gnt_idx];
         owner_idx <= gnt_idx;
      end else if (owner_vld && !req[owner_idx] && !lock[owner_idx]) begin
         owner_vld <= 1'b0;
      end
   end
`else
   logic unused_lock;
   assign unused_lock = ^lock;
   assign elig        = req;
`endif

   // Priority search starting at ptr, wrapping modulo N_REQ.
   always_comb begin
      int idx;
      idx     = 0;
      any_gnt = 1'b0;
      gnt_idx = '0;
      gnt     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!any_gnt && elig[IDX_W'(idx)]) begin
            any_gnt = 1'b1;
            gnt_idx = IDX_W'(idx);
         end
      end
      if (any_gnt) gnt[gnt_idx] = 1'b1;
   end

   assign rom_addr = any_gnt ? addr[gnt_idx*ADDR_W +: ADDR_W] : '0;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         ptr <= '0;
      else if (any_gnt)
         ptr <= (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + 1'b1;
   end

   // Stage 0 is the live grant; ROM_LAT registered stages follow it so the
   // tag lines up with rom_data at the return register.
   logic             last_vld;
   logic [IDX_W-1:0] last_idx;

   if (ROM_LAT == 0) begin : g_lat0
      assign last_vld = any_gnt;
      assign last_idx = gnt_idx;
   end else begin : g_pipe
      logic [ROM_LAT-1:0]            vld_pipe;
      logic [ROM_LAT-1:0][IDX_W-1:0] idx_pipe;

      always_ff @(posedge Clk or posedge Reset) begin
         if (Reset) begin
            vld_pipe <= '0;
            idx_pipe <= '0;
         end else begin
            vld_pipe[0] <= any_gnt;
            idx_pipe[0] <= gnt_idx;
            for (int k = 1; k < ROM_LAT; k++) begin
               vld_pipe[k] <= vld_pipe[k-1];
               idx_pipe[k] <= idx_pipe[k-1];
            end
         end
      end

      assign last_vld = vld_pipe[ROM_LAT-1];
      assign last_idx = idx_pipe[ROM_LAT-1];
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rvalid <= '0;
         rdata  <= '0;
      end else begin
         rvalid <= last_vld ? (N_REQ'(1) << last_idx) : '0;
         if (last_vld) rdata <= rom_data;
      end
   end

endmodule

// File: tb/tb_minion_rom_arbiter.sv
// Bench for minion_rom_arbiter: two instances (ROM_LAT 0 and 2) share stimulus
// and are compared every cycle against a behavioural round-robin model.
module tb_minion_rom_arbiter;

   localparam int N  = 4;
   localparam int AW = 19;
   localparam int DW = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req = '0;
   logic [N-1:0]    lock = '0;
   logic [N*AW-1:0] addr = '0;

   logic [N-1:0]  gnt0, gnt2, rv0, rv2;
   logic [AW-1:0] ra0, ra2, ad1, ad2;
   logic [DW-1:0] rd0, rd2, rdat0, rdat2;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
      return a[2:0] ^ a[5:3] ^ a[18:16];
   endfunction

   // ROM models: combinational for LAT 0, two-cycle registered for LAT 2.
   assign rd0 = mem(ra0);
   assign rd2 = mem(ad2);
   always @(posedge clk) begin
      ad1 <= ra2;
      ad2 <= ad1;
   end

   minion_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(0)) u_dut0 (
      .Clk(clk), .Reset(rst), .req(req), .addr(addr), .lock(lock),
      .gnt(gnt0), .rom_addr(ra0), .rom_data(rd0), .rdata(rdat0), .rvalid(rv0));

   minion_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2)) u_dut2 (
      .Clk(clk), .Reset(rst), .req(req), .addr(addr), .lock(lock),
      .gnt(gnt2), .rom_addr(ra2), .rom_data(rd2), .rdata(rdat2), .rvalid(rv2));

   // Model state: pointer, lock owner, and a per-cycle grant history.
   int            m_ptr = 0;
   bit            o_vld = 0;
   int            o_idx = 0;
   int            cyc = 0, start = 0;
   bit            hv [64];
   int            hi [64];
   logic [AW-1:0] ha [64];
   logic [DW-1:0] er0 = '0, er2 = '0;
   int            pass_cnt = 0, tot = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s cyc=%0d: got %0h want %0h", nm, cyc, act, exp);
   endtask

   function automatic int model_pick(input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         int i;
         bit ok;
         i  = (m_ptr + k) % N;
         ok = 1;
`ifdef MINION_ARB_LOCK_EN
         if (o_vld) ok = (i == o_idx);
`endif
         if (r[i] && ok) return i;
      end
      return -1;
   endfunction

   task automatic ret_chk(input int lat, input logic [N-1:0] rv, input logic [DW-1:0] rd,
                          inout logic [DW-1:0] er);
      int  j;
      bit  v;
      j = cyc - 1 - lat;
      v = (j >= start) && hv[j % 64];
      if (v) er = mem(ha[j % 64]);
      chk($sformatf("rvalid_lat%0d", lat), 32'(rv), v ? (32'd1 << hi[j % 64]) : 32'd0);
      chk($sformatf("rdata_lat%0d", lat), 32'(rd), 32'(er));
   endtask

   task automatic step(input logic [N-1:0] r, input logic [N*AW-1:0] a, input logic [N-1:0] l);
      int            g;
      logic [AW-1:0] ea;
      @(posedge clk);
      #1;
      rst = 1'b0; req = r; addr = a; lock = l;
      @(negedge clk);
      g  = model_pick(r);
      ea = (g >= 0) ? a[g*AW +: AW] : '0;
      chk("gnt_lat0", 32'(gnt0), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("gnt_lat2", 32'(gnt2), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("rom_addr_lat0", 32'(ra0), 32'(ea));
      chk("rom_addr_lat2", 32'(ra2), 32'(ea));
      ret_chk(0, rv0, rdat0, er0);
      ret_chk(2, rv2, rdat2, er2);
      hv[cyc % 64] = (g >= 0);
      hi[cyc % 64] = g;
      ha[cyc % 64] = ea;
      cyc++;
      if (g >= 0) begin
         m_ptr = (g + 1) % N;
`ifdef MINION_ARB_LOCK_EN
         o_vld = l[g];
         o_idx = g;
`endif
      end
`ifdef MINION_ARB_LOCK_EN
      else if (o_vld && !r[o_idx] && !l[o_idx]) o_vld = 0;
`endif
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1; req = '0; lock = '0;
      @(negedge clk);
      chk("rst_rvalid0", 32'(rv0), 32'd0);
      chk("rst_rvalid2", 32'(rv2), 32'd0);
      chk("rst_rdata0", 32'(rdat0), 32'd0);
      chk("rst_rdata2", 32'(rdat2), 32'd0);
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      cyc++;
      m_ptr = 0; o_vld = 0; er0 = '0; er2 = '0;
      start = cyc;
   endtask

   function automatic logic [N*AW-1:0] lane_addr(input int lane, input logic [AW-1:0] v);
      logic [N*AW-1:0] a;
      a = '0;
      a[lane*AW +: AW] = v;
      return a;
   endfunction

   initial begin
      logic [N*AW-1:0] ra;
      // Single requester, LAT 0 return.
      do_reset();
      step(4'b0100, lane_addr(2, 19'h0001F), 4'b0000);
      chk("t1_gnt", 32'(gnt0), 32'h4);
      chk("t1_rom_addr", 32'(ra0), 32'h1F);
      step(4'b0000, '0, 4'b0000);
      chk("t1_rvalid", 32'(rv0), 32'h4);
      chk("t1_rdata", 32'(rdat0), 32'h4);

      // Full contention rotation from reset.
      do_reset();
      step(4'b1111, '0, 4'b0000); chk("rot0", 32'(gnt0), 32'h1);
      step(4'b1111, '0, 4'b0000); chk("rot1", 32'(gnt0), 32'h2);
      chk("rot1_rv", 32'(rv0), 32'h1);
      step(4'b1111, '0, 4'b0000); chk("rot2", 32'(gnt0), 32'h4);
      step(4'b1111, '0, 4'b0000); chk("rot3", 32'(gnt0), 32'h8);
      step(4'b1111, '0, 4'b0000); chk("rot_wrap", 32'(gnt0), 32'h1);

      // LAT 2, back-to-back grants to requester 1.
      do_reset();
      step(4'b0010, lane_addr(1, 19'd5), 4'b0000);
      step(4'b0010, lane_addr(1, 19'd6), 4'b0000);
      step(4'b0010, lane_addr(1, 19'd7), 4'b0000);
      step(4'b0000, '0, 4'b0000);
      chk("lat2_rv_a", 32'(rv2), 32'h2); chk("lat2_rd_a", 32'(rdat2), 32'h5);
      step(4'b0000, '0, 4'b0000);
      chk("lat2_rv_b", 32'(rv2), 32'h2); chk("lat2_rd_b", 32'(rdat2), 32'h6);
      step(4'b0000, '0, 4'b0000);
      chk("lat2_rv_c", 32'(rv2), 32'h2); chk("lat2_rd_c", 32'(rdat2), 32'h7);

      // Reset with a tag in flight.
      do_reset();
      step(4'b0001, '0, 4'b0000);
      step(4'b1000, lane_addr(3, 19'd9), 4'b0000);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(4'b0000, '0, 4'b0000);
         chk("flush_rv2", 32'(rv2), 32'd0);
      end
      step(4'b1010, '0, 4'b0000);
      chk("post_rst_gnt", 32'(gnt2), 32'h2);

      // Lock burst from requester 0 with others contending.
      do_reset();
      step(4'b1111, '0, 4'b0001); chk("lock_g0", 32'(gnt0), 32'h1);
`ifdef MINION_ARB_LOCK_EN
      step(4'b1111, '0, 4'b0001); chk("lock_g1", 32'(gnt0), 32'h1);
      step(4'b1111, '0, 4'b0001); chk("lock_g2", 32'(gnt0), 32'h1);
`else
      step(4'b1111, '0, 4'b0001); chk("lock_g1", 32'(gnt0), 32'h2);
      step(4'b1111, '0, 4'b0001); chk("lock_g2", 32'(gnt0), 32'h4);
`endif
      for (int i = 0; i < 4; i++) step(4'b1110, '0, 4'b0000);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 49) == 0) do_reset();
         for (int i = 0; i < N; i++) ra[i*AW +: AW] = AW'($urandom);
         step(N'($urandom), ra, ($urandom_range(0, 3) == 0) ? N'($urandom) : '0);
      end

      $display("%0d/%0d checks passed", pass_cnt, tot);
      $finish;
   end

endmodule
